// File: rtl/speed_integrator.sv
`default_nettype none
// =============================================================================
// Module   : speed_integrator
// Purpose  : Integrates a signed Q0.32 speed into a queue of steps and drives
//            step/dir pulses with fixed pulse width and direction setup time.
//            Position counter enabled by macro SPEED_INTEGRATOR_POSITION_EN.
// Revision : 1.0
// =============================================================================
module speed_integrator #(
  parameter int PULSE_WIDTH = 20,
  parameter int DIR_SETUP   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] speed_in,
  input  logic               load_speeds,
  input  logic               set_pos,
  input  logic signed [31:0] pos_val,
  input  logic               clr_error,
  output logic               step,
  output logic               dir,
  output logic signed [31:0] position,
  output logic signed [31:0] speed,
  output logic signed [3:0]  pending,
  output logic               error_step_overrun
);

  localparam int CNT_MAX = (PULSE_WIDTH > DIR_SETUP) ? PULSE_WIDTH : DIR_SETUP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] DS_LAST = CNT_W'(DIR_SETUP - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DIR_SETUP  = 2'd1,
    S_PULSE_HIGH = 2'd2,
    S_PULSE_LOW  = 2'd3
  } state_t;

  logic signed [31:0] speed_q, speed_d;
  logic        [31:0] frac_q, frac_d;
  logic signed [3:0]  pending_q, pending_d;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic               err_q, err_d;

  logic [33:0]        sum;
  logic               gen_pos;
  logic               gen_neg;
  logic               decide;
  logic               deq;
  logic               pend_nz;
  logic               pend_pos;
  logic signed [4:0]  gen_delta;
  logic signed [4:0]  deq_delta;
  logic signed [4:0]  pend_base;
  logic signed [4:0]  pend_sum;
  logic               overflow;

  // Wrapping by +/-2^32 leaves the low 32 bits unchanged, so frac is always sum[31:0].
  always_comb begin
    sum     = {2'b00, frac_q} + {{2{speed_q[31]}}, speed_q};
    gen_neg = sum[33];
    gen_pos = !sum[33] && sum[32];
    frac_d  = sum[31:0];
    speed_d = load_speeds ? speed_in : speed_q;
  end

  assign pend_nz  = (pending_q != 4'sd0);
  assign pend_pos = !pending_q[3];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    dir_d   = dir_q;
    decide  = 1'b0;
    deq     = 1'b0;

    case (state_q)
      S_IDLE: begin
        decide = 1'b1;
      end
      S_DIR_SETUP: begin
        if (cnt_q == DS_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PULSE_HIGH: begin
        if (cnt_q == PW_LAST) begin
          state_d = S_PULSE_LOW;
          step_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PULSE_LOW: begin
        // Last low cycle doubles as the idle decision so back-to-back pulses run at 2*PULSE_WIDTH.
        if (cnt_q == PW_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          decide  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        step_d  = 1'b0;
      end
    endcase

    if (decide && pend_nz) begin
      if (dir_q == pend_pos) begin
        state_d = S_PULSE_HIGH;
        step_d  = 1'b1;
        cnt_d   = '0;
        deq     = 1'b1;
      end else begin
        state_d = S_DIR_SETUP;
        dir_d   = !dir_q;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    gen_delta = gen_pos ? 5'sd1 : (gen_neg ? -5'sd1 : 5'sd0);
    deq_delta = deq ? (dir_q ? 5'sd1 : -5'sd1) : 5'sd0;
    pend_base = {pending_q[3], pending_q} - deq_delta;
    pend_sum  = pend_base + gen_delta;
    overflow  = (pend_sum > 5'sd7) || (pend_sum < -5'sd7);
    pending_d = overflow ? pend_base[3:0] : pend_sum[3:0];
    err_d     = overflow || (err_q && !clr_error);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      speed_q   <= '0;
      frac_q    <= 32'h8000_0000;
      pending_q <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      speed_q   <= speed_d;
      frac_q    <= frac_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

`ifdef SPEED_INTEGRATOR_POSITION_EN
  logic signed [31:0] position_q, position_d;

  always_comb begin
    position_d = position_q;
    if (set_pos) begin
      position_d = pos_val;
    end else if (gen_pos) begin
      position_d = position_q + 32'sd1;
    end else if (gen_neg) begin
      position_d = position_q - 32'sd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      position_q <= '0;
    end else begin
      position_q <= position_d;
    end
  end

  assign position = position_q;
`else
  logic unused_pos;
  assign unused_pos = ^{set_pos, pos_val};
  assign position   = '0;
`endif

  assign step               = step_q;
  assign dir                = dir_q;
  assign speed              = speed_q;
  assign pending            = pending_q;
  assign error_step_overrun = err_q;

endmodule
`default_nettype wire

// File: doc/speed_integrator.md
SPEED_INTEGRATOR -- requirements
Module: speed_integrator

Interface
REQ-001 SHALL have parameter PULSE_WIDTH, default 20: cycles step is high, and minimum cycles low after each pulse.
REQ-002 SHALL have parameter DIR_SETUP, default 10: cycles dir must be stable before a step rising edge.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port speed_in  input  32  signed next speed from profile_gen, in steps/cycle, Q0.32.
REQ-006 SHALL have port load_speeds  input  1  one-cycle strobe from acc_step_gen; latches speed_in.
REQ-007 SHALL have port set_pos  input  1  one-cycle strobe; loads position from pos_val.
REQ-008 SHALL have port pos_val  input  32  signed position value for set_pos.
REQ-009 SHALL have port clr_error  input  1  clears error_step_overrun.
REQ-010 SHALL have port step  output  1  registered step pulse to driver.
REQ-011 SHALL have port dir  output  1  registered direction, 1 = positive.
REQ-012 SHALL have port position  output  32  signed count of generated steps.
REQ-013 SHALL have port speed  output  32  currently applied speed (debug).
REQ-014 SHALL have port pending  output  4  signed net queued steps (debug).
REQ-015 SHALL have port error_step_overrun  output  1  sticky queue overflow flag.

Function
REQ-016 On load_speeds, speed SHALL take speed_in; the new value is used for integration from the next cycle.
REQ-017 Each cycle: sum = zero-extended frac (33 b) + sign-extended speed (33 b), computed as 34-bit signed.
REQ-018 sum >= 2^32 -> one positive step generated; frac <= sum - 2^32.
REQ-019 sum < 0 -> one negative step generated; frac <= sum + 2^32.
REQ-020 Otherwise frac <= sum[31:0] and no step is generated.
REQ-021 A generated step SHALL update position by +1/-1 (32-bit wrap) and pending by +1/-1 in the following cycle.
REQ-022 If a generated step would make |pending| > 7, the step SHALL be dropped from pending, counted in position, and error_step_overrun SHALL set.
REQ-023 Output FSM states: S_IDLE, S_DIR_SETUP, S_PULSE_HIGH, S_PULSE_LOW.
REQ-024 S_IDLE, pending != 0, dir == sign(pending) -> S_PULSE_HIGH; step = 1 the next cycle; |pending| reduced by one in the same cycle.
REQ-025 S_IDLE, pending != 0, dir != sign(pending) -> dir toggles, then S_DIR_SETUP for DIR_SETUP cycles, then S_IDLE.
REQ-026 S_PULSE_HIGH SHALL hold step = 1 for exactly PULSE_WIDTH cycles, then go to S_PULSE_LOW.
REQ-027 S_PULSE_LOW SHALL hold step = 0 for PULSE_WIDTH cycles, then go to S_IDLE.
REQ-028 When a generated step and an FSM dequeue occur in the same cycle, both SHALL apply; net pending change is the sum.
REQ-029 Opposite-direction steps SHALL cancel in pending; dir changes only when a pulse of the new sign is due.
REQ-030 set_pos SHALL override any position update in the same cycle.
REQ-031 error_step_overrun: clr_error clears it unless an overflow occurs in the same cycle (set wins).

Reset
REQ-032 Reset values: speed = 0, frac = 0x8000_0000, position = 0, pending = 0, state = S_IDLE, step = 0, dir = 1, error_step_overrun = 0.
REQ-033 Reset mid-pulse SHALL drop step to 0 in the next cycle and discard all queued steps.

Configuration
REQ-034 Macro SPEED_INTEGRATOR_POSITION_EN: when defined, position, set_pos and pos_val are functional as above.
REQ-035 When SPEED_INTEGRATOR_POSITION_EN is undefined, position SHALL read 0 and set_pos/pos_val SHALL be ignored; the port list is unchanged and step generation is unaffected.

Verification
REQ-036 PULSE_WIDTH=2, DIR_SETUP=1; reset; load_speeds with speed_in = 0x4000_0000 -> first step generated 2 cycles after load takes effect, then one every 4 cycles, no overrun, position increments by 1 per pulse.
REQ-037 speed_in = 0xC000_0000 (-0.25) after reset -> dir = 0 before first pulse, at least 1 setup cycle before the step rises; position decrements.
REQ-038 Defaults (20/10), speed_in = 0x8000_0000 magnitude-limited 0x7FFF_FFFF -> pending saturates at 7, error_step_overrun = 1, position still counts every generated step.
REQ-039 pending = +3, then speed reversed -> pending drains through 0 toward negative values; no negative pulse is issued while pending > 0; dir toggles only once.
REQ-040 set_pos with pos_val = 0x0000_1000 in the same cycle as a generated step -> position = 0x0000_1000.
REQ-041 Reset asserted during S_PULSE_HIGH -> step = 0 the next cycle, pending = 0, frac = 0x8000_0000.
